// File: rtl/stack_self_test.sv
// Per-layer self-test and chip-ID enumeration controller for a 3D die stack.
// Receives a training burst plus sync frame from below, forwards it upward, and reports pass/fail.
module stack_self_test #(
    parameter int          DATA_W     = 32,
    parameter int          NUM_PAT    = 16,
    parameter int          ID_W       = 3,
    parameter int          MAX_LAYERS = 8,
    parameter logic [15:0] SYNC_WORD  = 16'hBEAF,
    parameter int          TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_layer,
    input  logic              t_layer,
    input  logic              vld_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              done_in,
    output logic              en,
    output logic [DATA_W-1:0] data_out,
    output logic              done_out,
    output logic [ID_W-1:0]   chip_id,
    output logic [7:0]        err_cnt,
    output logic              pass,
    output logic              fail
);

    // Handshake: a word on data_in is consumed on every rising edge where vld_in=1 in a
    // receive state; there is no back-pressure, so en/data_out form a one-way valid stream.

    localparam int KW = $clog2(NUM_PAT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [KW-1:0] K_LAST = KW'(NUM_PAT - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, RX_PAT, RX_SYNC, TX_PAT, TX_SYNC, WAIT_DONE, STANDBY, FAIL
    } state_t;

    state_t            state, next_state;
    logic [KW-1:0]     k_cnt, k_d;
    logic [TW-1:0]     to_cnt, to_d;
    logic              en_d, done_d, pass_d, fail_d;
    logic [DATA_W-1:0] data_d;
    logic [ID_W-1:0]   chip_id_d;
    logic [7:0]        err_d;
    logic              timed_out, id_ok, sync_ok;

    function automatic logic [DATA_W-1:0] pattern(input logic [KW-1:0] k);
        logic [DATA_W-1:0] p;
        int idx;
        idx = int'(k) % DATA_W;
        p = '0;
        p[idx] = 1'b1;
        if (k[0]) p = p ^ {DATA_W/2{2'b10}};
        return p;
    endfunction

    function automatic logic [DATA_W-1:0] sync_frame(input logic [ID_W-1:0] id);
        logic [DATA_W-1:0] f;
        f = '0;
        f[15:0] = SYNC_WORD;
        f[16 +: ID_W] = id;
        return f;
    endfunction

    assign timed_out = (to_cnt == T_LAST);
    assign id_ok     = int'(data_in[16 +: ID_W]) < MAX_LAYERS;
    assign sync_ok   = (data_in[15:0] == SYNC_WORD) && id_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            en       <= 1'b0;
            data_out <= '0;
            done_out <= 1'b0;
            chip_id  <= '0;
            err_cnt  <= '0;
            pass     <= 1'b0;
            fail     <= 1'b0;
            k_cnt    <= '0;
            to_cnt   <= '0;
        end else begin
            state    <= next_state;
            en       <= en_d;
            data_out <= data_d;
            done_out <= done_d;
            chip_id  <= chip_id_d;
            err_cnt  <= err_d;
            pass     <= pass_d;
            fail     <= fail_d;
            k_cnt    <= k_d;
            to_cnt   <= to_d;
        end
    end

    always_comb begin
        next_state = state;
        en_d       = 1'b0;
        data_d     = '0;
        done_d     = done_out;
        chip_id_d  = chip_id;
        err_d      = err_cnt;
        pass_d     = pass;
        fail_d     = fail;
        k_d        = k_cnt;
        to_d       = to_cnt;

        case (state)
            IDLE: begin
                if (f_layer) begin
                    chip_id_d  = '0;
                    next_state = TX_PAT;
                end else begin
                    next_state = RX_PAT;
                end
            end
            RX_PAT: begin
                if (vld_in) begin
                    to_d = '0;
                    if ((data_in != pattern(k_cnt)) && (err_cnt != 8'hFF))
                        err_d = err_cnt + 8'd1;
                    if (k_cnt == K_LAST) next_state = RX_SYNC;
                    else                 k_d = k_cnt + KW'(1);
                end else if (timed_out) begin
                    next_state = FAIL;
                end else begin
                    to_d = to_cnt + TW'(1);
                end
            end
            RX_SYNC: begin
                if (vld_in) begin
                    to_d = '0;
                    if (sync_ok) begin
                        chip_id_d  = data_in[16 +: ID_W];
                        next_state = t_layer ? WAIT_DONE : TX_PAT;
                    end else begin
                        next_state = FAIL;
                    end
                end else if (timed_out) begin
                    next_state = FAIL;
                end else begin
                    to_d = to_cnt + TW'(1);
                end
            end
            TX_PAT: begin
                en_d   = 1'b1;
                data_d = pattern(k_cnt);
                if (k_cnt == K_LAST) next_state = TX_SYNC;
                else                 k_d = k_cnt + KW'(1);
            end
            TX_SYNC: begin
                // Outgoing ID wraps naturally in ID_W bits; the layer above rejects it if illegal.
                en_d       = 1'b1;
                data_d     = sync_frame(chip_id + ID_W'(1));
                next_state = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (t_layer || done_in) next_state = STANDBY;
                else if (timed_out)     next_state = FAIL;
                else                    to_d = to_cnt + TW'(1);
            end
            STANDBY, FAIL: ;
            default: next_state = IDLE;
        endcase

        // Counters restart on every state entry.
        if (next_state != state) begin
            k_d  = '0;
            to_d = '0;
        end
        if (next_state == STANDBY) begin
            done_d = 1'b1;
            pass_d = (err_cnt == 8'd0);
        end
        if (next_state == FAIL) begin
            done_d = 1'b1;
            pass_d = 1'b0;
            fail_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_stack_self_test.sv
// Bench for stack_self_test: a bottom+top chain, a bench-driven middle layer, and a
// 4-bit-ID instance sharing the middle-layer stimulus for the out-of-range ID case.
module tb_stack_self_test;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_b, rst_m;
    logic        m_vld, m_done_in;
    logic [31:0] m_data;

    logic        b_en, b_done_out, b_pass, b_fail;
    logic [31:0] b_data;
    logic [2:0]  b_id;
    logic [7:0]  b_err;
    logic        t_en, t_done_out, t_pass, t_fail;
    logic [31:0] t_data;
    logic [2:0]  t_id;
    logic [7:0]  t_err;
    logic        m_en, m_done_out, m_pass, m_fail;
    logic [31:0] m_data_out;
    logic [2:0]  m_id;
    logic [7:0]  m_err;
    logic        w_en, w_done_out, w_pass, w_fail;
    logic [31:0] w_data_out;
    logic [3:0]  w_id;
    logic [7:0]  w_err;

    stack_self_test dut_b (
        .clk(clk), .rst_n(rst_b), .f_layer(1'b1), .t_layer(1'b0),
        .vld_in(1'b0), .data_in(32'h0), .done_in(t_done_out),
        .en(b_en), .data_out(b_data), .done_out(b_done_out), .chip_id(b_id),
        .err_cnt(b_err), .pass(b_pass), .fail(b_fail)
    );

    stack_self_test dut_t (
        .clk(clk), .rst_n(rst_b), .f_layer(1'b0), .t_layer(1'b1),
        .vld_in(b_en), .data_in(b_data), .done_in(1'b0),
        .en(t_en), .data_out(t_data), .done_out(t_done_out), .chip_id(t_id),
        .err_cnt(t_err), .pass(t_pass), .fail(t_fail)
    );

    stack_self_test dut_m (
        .clk(clk), .rst_n(rst_m), .f_layer(1'b0), .t_layer(1'b0),
        .vld_in(m_vld), .data_in(m_data), .done_in(m_done_in),
        .en(m_en), .data_out(m_data_out), .done_out(m_done_out), .chip_id(m_id),
        .err_cnt(m_err), .pass(m_pass), .fail(m_fail)
    );

    stack_self_test #(.ID_W(4), .MAX_LAYERS(8)) dut_w (
        .clk(clk), .rst_n(rst_m), .f_layer(1'b0), .t_layer(1'b0),
        .vld_in(m_vld), .data_in(m_data), .done_in(m_done_in),
        .en(w_en), .data_out(w_data_out), .done_out(w_done_out), .chip_id(w_id),
        .err_cnt(w_err), .pass(w_pass), .fail(w_fail)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_b[$];
    logic [31:0] exp_m[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Pattern k for a 32-bit bus: one-hot bit k, odd words inverted against 0xAAAAAAAA.
    function automatic logic [31:0] exp_pat(input int k);
        logic [31:0] w;
        w = 32'h1 << k;
        if (k % 2 == 1) w = w ^ 32'hAAAA_AAAA;
        return w;
    endfunction

    task automatic push_b(input logic [3:0] next_id);
        for (int k = 0; k < 16; k++) exp_b.push_back(exp_pat(k));
        exp_b.push_back({12'h0, next_id, 16'hBEAF});
    endtask

    task automatic push_m(input logic [3:0] next_id);
        for (int k = 0; k < 16; k++) exp_m.push_back(exp_pat(k));
        exp_m.push_back({12'h0, next_id, 16'hBEAF});
    endtask

    task automatic start_m();
        rst_m = 1'b0;
        m_vld = 1'b0;
        m_data = '0;
        m_done_in = 1'b0;
        @(posedge clk); #1;
        rst_m = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_burst(input int bad1, input int bad2);
        for (int k = 0; k < 16; k++) begin
            m_vld = 1'b1;
            m_data = exp_pat(k) ^ (((k == bad1) || (k == bad2)) ? 32'h0000_0100 : 32'h0);
            @(posedge clk); #1;
        end
    endtask

    task automatic send_sync(input logic [15:0] hdr, input logic [3:0] id);
        m_vld = 1'b1;
        m_data = {12'h0, id, hdr};
        @(posedge clk); #1;
        m_vld = 1'b0;
        m_data = '0;
    endtask

    task automatic drain_m(input string name);
        for (int i = 0; i < 60 && exp_m.size() != 0; i++) @(posedge clk);
        #1;
        check(name, exp_m.size(), 0);
    endtask

    // Monitor: pops an expected word whenever a layer presents en.
    always @(negedge clk) begin
        if (b_en) begin
            if (exp_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_extra_word: got %h, expected no word", b_data);
            end else begin
                check("b_word", b_data, exp_b.pop_front());
            end
        end
        if (m_en) begin
            if (exp_m.size() == 0) begin
                checks++; errors++;
                $display("FAIL m_extra_word: got %h, expected no word", m_data_out);
            end else begin
                check("m_word", m_data_out, exp_m.pop_front());
            end
        end
    end

    initial begin
        int cyc;
        rst_b = 1'b0; rst_m = 1'b0;
        m_vld = 1'b0; m_data = '0; m_done_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        check("rst_en", m_en, 0);
        check("rst_data_out", m_data_out, 0);
        check("rst_done_out", m_done_out, 0);
        check("rst_chip_id", m_id, 0);
        check("rst_err_cnt", m_err, 0);
        check("rst_pass", m_pass, 0);
        check("rst_fail", m_fail, 0);

        // Bottom + top chain with first-word latency.
        push_b(4'd1);
        rst_b = 1'b1;
        @(posedge clk); #1;
        check("lat_edge1_en", b_en, 0);
        @(posedge clk); #1;
        check("lat_edge2_en", b_en, 1);
        for (int i = 0; i < 100 && !(b_pass || b_fail); i++) @(posedge clk);
        #1;
        check("chain_b_pass", b_pass, 1);
        check("chain_b_done_out", b_done_out, 1);
        check("chain_b_fail", b_fail, 0);
        check("chain_t_chip_id", t_id, 1);
        check("chain_t_done_out", t_done_out, 1);
        check("chain_t_pass", t_pass, 1);
        check("chain_b_words_left", exp_b.size(), 0);

        // Asynchronous reset in the middle of the bottom layer's burst, then restart.
        rst_b = 1'b0;
        @(posedge clk); #1;
        push_b(4'd1);
        rst_b = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("midtx_en_before", b_en, 1);
        #2;
        rst_b = 1'b0;
        #1;
        check("midtx_async_en", b_en, 0);
        check("midtx_async_data", b_data, 0);
        exp_b.delete();
        @(posedge clk); #1;
        push_b(4'd1);
        rst_b = 1'b1;
        for (int i = 0; i < 100 && !(b_pass || b_fail); i++) @(posedge clk);
        #1;
        check("restart_b_pass", b_pass, 1);
        check("restart_t_chip_id", t_id, 1);
        check("restart_b_words_left", exp_b.size(), 0);

        // Middle layer, clean burst, ID 2.
        start_m();
        push_m(4'd3);
        send_burst(-1, -1);
        send_sync(16'hBEAF, 4'd2);
        drain_m("mid_drain");
        repeat (2) @(posedge clk);
        #1;
        check("mid_chip_id", m_id, 2);
        check("mid_err_cnt", m_err, 0);
        check("mid_wait_done_out", m_done_out, 0);
        check("mid_wait_pass", m_pass, 0);
        m_done_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mid_pass", m_pass, 1);
        check("mid_done_out", m_done_out, 1);
        check("mid_fail", m_fail, 0);

        // Middle layer with patterns 3 and 9 corrupted.
        start_m();
        push_m(4'd3);
        send_burst(3, 9);
        send_sync(16'hBEAF, 4'd2);
        drain_m("bad_drain");
        m_done_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("bad_err_cnt", m_err, 2);
        check("bad_pass", m_pass, 0);
        check("bad_fail", m_fail, 0);
        check("bad_done_out", m_done_out, 1);

        // Wrong sync header.
        start_m();
        send_burst(-1, -1);
        send_sync(16'hBEEF, 4'd2);
        repeat (40) @(posedge clk);
        #1;
        check("hdr_fail", m_fail, 1);
        check("hdr_done_out", m_done_out, 1);
        check("hdr_pass", m_pass, 0);
        check("hdr_en", m_en, 0);

        // ID 8 on a 4-bit-ID layer with MAX_LAYERS=8; the 3-bit layer sees ID 0.
        start_m();
        push_m(4'd1);
        send_burst(-1, -1);
        send_sync(16'hBEAF, 4'd8);
        repeat (3) @(posedge clk);
        #1;
        check("id8_fail", w_fail, 1);
        check("id8_done_out", w_done_out, 1);
        check("id8_en", w_en, 0);
        drain_m("id8_m_drain");

        // ID MAX_LAYERS-1 is legal; outgoing ID wraps to 0.
        start_m();
        push_m(4'd0);
        send_burst(-1, -1);
        send_sync(16'hBEAF, 4'd7);
        drain_m("wrap_drain");
        check("wrap_chip_id", m_id, 7);
        check("wrap_fail", m_fail, 0);

        // No input at all: timeout to FAIL after about TIMEOUT cycles.
        rst_m = 1'b0;
        m_done_in = 1'b0;
        @(posedge clk); #1;
        rst_m = 1'b1;
        cyc = 0;
        while (!m_fail && cyc < 1200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("timeout_fail", m_fail, 1);
        check("timeout_done_out", m_done_out, 1);
        check("timeout_window", ((cyc >= 1000) && (cyc <= 1050)) ? 32'd1 : 32'd0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
